// File: rtl/spi_w25q16_pro.sv
// ============================================================================
// Module   : spi_w25q16_pro
// Brief    : One debounced key press runs a W25Q16 write sequence over SPI
//            mode 0 (WREN, then page program). The optional sector erase is
//            enabled by the macro SECTOR_ERASE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_w25q16_pro #(
    parameter int          DEBOUNCE_CNT = 1_000_000,
    parameter logic [23:0] FLASH_ADDR   = 24'h000000,
    parameter int          PP_BYTES     = 10,
    parameter int          ERASE_WAIT   = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic spi_clk,
    output logic cs,
    output logic spi_mosi
);

    localparam int c_DB_W     = $clog2(DEBOUNCE_CNT + 1);
    localparam int c_WAIT_MAX = (ERASE_WAIT > 8) ? ERASE_WAIT : 8;
    localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_DB_W-1:0]   c_DB_MAX   = c_DB_W'(DEBOUNCE_CNT);
    localparam logic [8:0]          c_PP_LAST  = 9'(PP_BYTES + 3);
    localparam logic [c_WAIT_W-1:0] c_GAP_LAST = c_WAIT_W'(7);
`ifdef SECTOR_ERASE_EN
    localparam logic [c_WAIT_W-1:0] c_HOLD_LAST = c_WAIT_W'(c_WAIT_MAX - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WREN       = 4'd1,
        S_GAP        = 4'd2,
`ifdef SECTOR_ERASE_EN
        S_ERASE      = 4'd3,
        S_ERASE_WAIT = 4'd4,
        S_WREN2      = 4'd5,
        S_GAP2       = 4'd6,
`endif
        S_PP         = 4'd7,
        S_DONE       = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        SEG_LEAD  = 2'd0,
        SEG_SHIFT = 2'd1,
        SEG_TRAIL = 2'd2
    } seg_t;

    logic              r_key_s1;
    logic              r_key_s2;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_press;

    state_t              r_state, w_state_nxt;
    seg_t                r_seg, w_seg_nxt;
    logic [1:0]          r_ph, w_ph_nxt;
    logic [2:0]          r_bit, w_bit_nxt;
    logic [8:0]          r_byte, w_byte_nxt;
    logic [c_WAIT_W-1:0] r_wait, w_wait_nxt;
    logic                r_cs, r_sclk, r_mosi;
    logic                w_cs_nxt, w_sclk_nxt, w_mosi_nxt;

    logic       w_in_frame;
    logic       w_frame_done;
    logic [8:0] w_last_byte;
    logic [7:0] w_tx;
    logic [7:0] w_data;

    // The counter saturates one past the trigger value so a held key fires once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            if (r_key_s2)
                r_db_cnt <= '0;
            else if (r_db_cnt != c_DB_MAX)
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
    end

    assign w_press = !r_key_s2 && (r_db_cnt == c_DB_LAST);
    assign w_data  = r_byte[7:0] - 8'd4;

    // Byte to shift for the current frame and its last byte index.
    always_comb begin
        w_in_frame  = 1'b0;
        w_last_byte = 9'd0;
        w_tx        = 8'h00;
        case (r_state)
            S_WREN: begin
                w_in_frame = 1'b1;
                w_tx       = 8'h06;
            end
`ifdef SECTOR_ERASE_EN
            S_WREN2: begin
                w_in_frame = 1'b1;
                w_tx       = 8'h06;
            end
            S_ERASE: begin
                w_in_frame  = 1'b1;
                w_last_byte = 9'd3;
                case (r_byte)
                    9'd0:    w_tx = 8'h20;
                    9'd1:    w_tx = FLASH_ADDR[23:16];
                    9'd2:    w_tx = FLASH_ADDR[15:8];
                    9'd3:    w_tx = FLASH_ADDR[7:0];
                    default: w_tx = 8'h00;
                endcase
            end
`endif
            S_PP: begin
                w_in_frame  = 1'b1;
                w_last_byte = c_PP_LAST;
                case (r_byte)
                    9'd0:    w_tx = 8'h02;
                    9'd1:    w_tx = FLASH_ADDR[23:16];
                    9'd2:    w_tx = FLASH_ADDR[15:8];
                    9'd3:    w_tx = FLASH_ADDR[7:0];
                    default: w_tx = w_data;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_seg_nxt    = r_seg;
        w_ph_nxt     = r_ph;
        w_bit_nxt    = r_bit;
        w_byte_nxt   = r_byte;
        w_wait_nxt   = r_wait;
        w_cs_nxt     = 1'b1;
        w_sclk_nxt   = 1'b0;
        w_mosi_nxt   = 1'b0;
        w_frame_done = 1'b0;

        // Each frame: 4 lead cycles, 4 cycles per bit, 4 trail cycles.
        if (w_in_frame) begin
            w_cs_nxt = 1'b0;
            w_ph_nxt = r_ph + 2'd1;
            case (r_seg)
                SEG_LEAD: begin
                    if (r_ph == 2'd3)
                        w_seg_nxt = SEG_SHIFT;
                end
                SEG_SHIFT: begin
                    w_sclk_nxt = r_ph[1];
                    w_mosi_nxt = w_tx[3'd7 - r_bit];
                    if (r_ph == 2'd3) begin
                        w_bit_nxt = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (r_byte == w_last_byte)
                                w_seg_nxt = SEG_TRAIL;
                            else
                                w_byte_nxt = r_byte + 9'd1;
                        end
                    end
                end
                SEG_TRAIL: begin
                    if (r_ph == 2'd3) begin
                        w_frame_done = 1'b1;
                        w_seg_nxt    = SEG_LEAD;
                        w_byte_nxt   = 9'd0;
                    end
                end
                default: w_seg_nxt = SEG_LEAD;
            endcase
        end

        case (r_state)
            S_IDLE: begin
                if (w_press)
                    w_state_nxt = S_WREN;
            end
            S_WREN: begin
                if (w_frame_done)
                    w_state_nxt = S_GAP;
            end
            S_GAP: begin
                w_wait_nxt = r_wait + c_WAIT_W'(1);
                if (r_wait == c_GAP_LAST) begin
                    w_wait_nxt = '0;
`ifdef SECTOR_ERASE_EN
                    w_state_nxt = S_ERASE;
`else
                    w_state_nxt = S_PP;
`endif
                end
            end
`ifdef SECTOR_ERASE_EN
            S_ERASE: begin
                if (w_frame_done)
                    w_state_nxt = S_ERASE_WAIT;
            end
            S_ERASE_WAIT: begin
                w_wait_nxt = r_wait + c_WAIT_W'(1);
                if (r_wait == c_HOLD_LAST) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = S_WREN2;
                end
            end
            S_WREN2: begin
                if (w_frame_done)
                    w_state_nxt = S_GAP2;
            end
            S_GAP2: begin
                w_wait_nxt = r_wait + c_WAIT_W'(1);
                if (r_wait == c_GAP_LAST) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = S_PP;
                end
            end
`endif
            S_PP: begin
                if (w_frame_done)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_seg   <= SEG_LEAD;
            r_ph    <= 2'd0;
            r_bit   <= 3'd0;
            r_byte  <= 9'd0;
            r_wait  <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
            r_ph    <= w_ph_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_wait  <= w_wait_nxt;
            r_cs    <= w_cs_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
        end
    end

    assign cs       = r_cs;
    assign spi_clk  = r_sclk;
    assign spi_mosi = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_w25q16_pro.sv
// ============================================================================
// Module   : tb_spi_w25q16_pro
// Brief    : Self-checking bench for spi_w25q16_pro; decodes SPI frames and
//            compares them with an expected-frame queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_w25q16_pro;

    localparam int          D    = 16;
    localparam logic [23:0] ADDR = 24'h12_34_56;
    localparam int          NPP  = 10;
    localparam int          EW   = 100;
`ifdef SECTOR_ERASE_EN
    localparam int FRAMES_PER_SEQ = 4;
    localparam int BYTES_PER_SEQ  = 20;
`else
    localparam int FRAMES_PER_SEQ = 2;
    localparam int BYTES_PER_SEQ  = 15;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic key   = 1'b1;
    logic spi_clk, cs, spi_mosi;

    spi_w25q16_pro #(
        .DEBOUNCE_CNT (D),
        .FLASH_ADDR   (ADDR),
        .PP_BYTES     (NPP),
        .ERASE_WAIT   (EW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .spi_clk  (spi_clk),
        .cs       (cs),
        .spi_mosi (spi_mosi)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [23:0] addr_v = ADDR;
    logic [7:0]  exp_b[$];
    int          exp_len[$];
    int          exp_gap[$];
    logic [7:0]  last_frame[$];
    int          frames_seen = 0;
    int          bytes_seen  = 0;
    bit          abort_flag  = 1'b0;

    int         cyc = 0, hi_run = 0, fall_cyc = 0, last_rise = 0, last_fall = 0, rises = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] cap[$];
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_frame_hdr(input int gap, input int len);
        exp_gap.push_back(gap);
        exp_len.push_back(len);
    endtask

    // Model: the frames one accepted press must produce, in order.
    task automatic expect_sequence();
        push_frame_hdr(8, 1);
        exp_b.push_back(8'h06);
`ifdef SECTOR_ERASE_EN
        push_frame_hdr(8, 4);
        exp_b.push_back(8'h20);
        exp_b.push_back(addr_v[23:16]);
        exp_b.push_back(addr_v[15:8]);
        exp_b.push_back(addr_v[7:0]);
        push_frame_hdr(EW, 1);
        exp_b.push_back(8'h06);
`endif
        push_frame_hdr(8, 4 + NPP);
        exp_b.push_back(8'h02);
        exp_b.push_back(addr_v[23:16]);
        exp_b.push_back(addr_v[15:8]);
        exp_b.push_back(addr_v[7:0]);
        for (int i = 0; i < NPP; i++)
            exp_b.push_back(8'(i));
    endtask

    task automatic end_frame();
        int         n;
        logic [7:0] a;
        logic [7:0] e;
        if (abort_flag) begin
            abort_flag = 1'b0;
            if (exp_len.size() > 0) begin
                n = exp_len.pop_front();
                void'(exp_gap.pop_front());
                repeat (n) void'(exp_b.pop_front());
            end
            return;
        end
        frames_seen++;
        bytes_seen += cap.size();
        last_frame = cap;
        if (exp_len.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: actual=%0d bytes required=no frame", cap.size());
            return;
        end
        n = exp_len.pop_front();
        void'(exp_gap.pop_front());
        check("frame_len", 32'(cap.size()), 32'(n));
        check("sclk_rises", 32'(rises), 32'(8 * n));
        check("trail_cycles", 32'(cyc - last_fall), 32'd4);
        for (int i = 0; i < n; i++) begin
            e = exp_b.pop_front();
            a = (i < cap.size()) ? cap[i] : 8'hxx;
            check($sformatf("frame_byte%0d", i), {24'd0, a}, {24'd0, e});
        end
    endtask

    // Compare process: line rules every cycle, frame content at each cs rise.
    always @(negedge clk) begin
        cyc++;
        if (cs === 1'b1) begin
            check("idle_lines", 32'({spi_clk, spi_mosi}), 32'd0);
            if (prev_cs === 1'b0)
                end_frame();
            hi_run++;
        end else begin
            if (prev_cs === 1'b1) begin
                if (exp_gap.size() > 0)
                    check("cs_gap", 32'(hi_run >= exp_gap[0]), 32'd1);
                fall_cyc  = cyc;
                last_fall = cyc;
                rises     = 0;
                cap.delete();
            end
            hi_run = 0;
            if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
                if (rises == 0)
                    check("lead_cycles", 32'(cyc - fall_cyc), 32'd6);
                else
                    check("sclk_period", 32'(cyc - last_rise), 32'd4);
                last_rise = cyc;
                rises++;
                cur = {cur[6:0], spi_mosi};
                if (rises % 8 == 0)
                    cap.push_back(cur);
            end
            if (spi_clk === 1'b0 && prev_sclk === 1'b1)
                last_fall = cyc;
        end
        prev_cs   = cs;
        prev_sclk = spi_clk;
    end

    // mode 0: no frame may start; 1: one sequence expected; 2: DUT busy.
    task automatic press(input int low, input int mode);
        int lat;
        int span;
        lat  = -1;
        span = (low > D + 50) ? low : D + 50;
        if (mode == 1)
            expect_sequence();
        @(negedge clk);
        key = 1'b0;
        for (int n = 1; n <= span; n++) begin
            @(negedge clk);
            if (n == low)
                key = 1'b1;
            if (lat < 0 && cs === 1'b0)
                lat = n;
        end
        if (mode == 1)
            check("press_latency", 32'(lat), 32'(D + 3));
        else if (mode == 0)
            check("no_cs_activity", 32'(lat), 32'hFFFF_FFFF);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_len.size() != 0 || cs !== 1'b1) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_complete"}, 32'(t < 5000), 32'd1);
        repeat (100) @(negedge clk);
    endtask

    initial begin
        int   base;
        int   t;
        logic any_low;

        rst_n = 1'b0;
        #14;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(spi_clk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        repeat (100) @(negedge clk);
        check("no_frame_after_reset", 32'(frames_seen), 32'd0);

        press(D - 1, 0);
        check("short_press_frames", 32'(frames_seen), 32'd0);

        any_low = 1'b0;
        repeat (6) begin
            key = 1'b0;
            repeat (D - 3) begin
                @(negedge clk);
                if (cs === 1'b0) any_low = 1'b1;
            end
            key = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (cs === 1'b0) any_low = 1'b1;
            end
        end
        repeat (60) begin
            @(negedge clk);
            if (cs === 1'b0) any_low = 1'b1;
        end
        check("bounce_no_cs", 32'(any_low), 32'd0);
        check("bounce_frames", 32'(frames_seen), 32'd0);

        press(D, 1);
        wait_done("seq1");
        check("seq1_frames", 32'(frames_seen), 32'(FRAMES_PER_SEQ));
        check("seq1_bytes", 32'(bytes_seen), 32'(BYTES_PER_SEQ));
        check("pp_opcode", {24'd0, last_frame[0]}, 32'h02);
        check("pp_addr_hi", {24'd0, last_frame[1]}, 32'h12);
        check("pp_addr_lo", {24'd0, last_frame[3]}, 32'h56);
        check("pp_data_first", {24'd0, last_frame[4]}, 32'h00);
        check("pp_data_last", {24'd0, last_frame[13]}, 32'h09);

        base = frames_seen;
        press(D + 3, 1);
        press(D + 5, 2);
        wait_done("seq_busy");
        check("busy_press_ignored", 32'(frames_seen - base), 32'(FRAMES_PER_SEQ));

        base = frames_seen;
        press(2000, 1);
        wait_done("seq_hold");
        check("hold_single_sequence", 32'(frames_seen - base), 32'(FRAMES_PER_SEQ));

        base = frames_seen;
        press(D, 1);
        t = 0;
        while (frames_seen < base + FRAMES_PER_SEQ - 1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        while (cs !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reach_pp_frame", 32'(t < 5000), 32'd1);
        repeat (60) @(negedge clk);
        abort_flag = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_cs_high", 32'(cs), 32'd1);
        check("abort_sclk_low", 32'(spi_clk), 32'd0);
        repeat (200) @(negedge clk);
        check("abort_no_restart", 32'(frames_seen - base), 32'(FRAMES_PER_SEQ - 1));
        check("abort_flushed", 32'(exp_len.size()), 32'd0);

        base = frames_seen;
        press(D, 1);
        wait_done("seq_after_abort");
        check("after_abort_frames", 32'(frames_seen - base), 32'(FRAMES_PER_SEQ));
        check("model_drained", 32'(exp_len.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
